// File: rtl/ecpddr_rdlevel_pkg.sv
// Shared definitions for the ECP5 DDR3 read-leveling trainer.
package ecpddr_rdlevel_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StReq,
    StWait,
    StEval,
    StDone
  } state_e;

  // Expected 4-beat byte pattern per lane, beat 0 in the least significant byte.
  localparam logic [31:0] DefaultPattern = 32'ha55a_0ff0;
  localparam int unsigned BeatsPerRead   = 4;

  // Bit offset of lane l, beat b in the PHY read-data word (beats outermost).
  function automatic int unsigned byte_lsb(input int unsigned lane, input int unsigned beat,
                                           input int unsigned nlanes);
    return beat * nlanes * 8 + lane * 8;
  endfunction

endpackage

// File: rtl/ecpddr_rdlevel_win.sv
// Per-lane window tracker: follows the current run of passing codes, keeps the longest one
// seen so far and presents its centre code.
module ecpddr_rdlevel_win
  import ecpddr_rdlevel_pkg::*;
#(
  parameter int unsigned RDLY_W  = 3,
  parameter int unsigned MIN_WIN = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,   // start of a new sweep
  input  logic              i_update,  // final verdict for i_code is on i_pass
  input  logic              i_pass,
  input  logic              i_last,    // i_code is the last code of the sweep
  input  logic [RDLY_W-1:0] i_code,
  output logic [RDLY_W-1:0] o_mid,
  output logic              o_good
);

  // One extra bit so a run covering the whole sweep fits.
  localparam int unsigned LenW = RDLY_W + 1;

  logic [LenW-1:0]   cur_len_q, best_len_q, run_len;
  logic [RDLY_W-1:0] cur_start_q, best_start_q, run_start;
  logic [LenW-1:0]   mid_full;

  // Run as it stands once this code's verdict is folded in.
  always_comb begin
    run_len   = i_pass ? cur_len_q + 1'b1 : cur_len_q;
    run_start = (i_pass && (cur_len_q == '0)) ? i_code : cur_start_q;
  end

  // Extend the open run on a pass; a fail or the end of the sweep closes it and the
  // closed run only displaces the best on a strictly longer length.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cur_len_q    <= '0;
      cur_start_q  <= '0;
      best_len_q   <= '0;
      best_start_q <= '0;
    end else if (i_clear) begin
      cur_len_q    <= '0;
      cur_start_q  <= '0;
      best_len_q   <= '0;
      best_start_q <= '0;
    end else if (i_update) begin
      if (i_pass && !i_last) begin
        cur_len_q   <= run_len;
        cur_start_q <= run_start;
      end else begin
        cur_len_q <= '0;
        if (run_len > best_len_q) begin
          best_len_q   <= run_len;
          best_start_q <= run_start;
        end
      end
    end
  end

  // Floor centre of the best window; stays in range whenever o_good is set.
  assign mid_full = {1'b0, best_start_q} + ((best_len_q - 1'b1) >> 1);
  assign o_mid    = mid_full[RDLY_W-1:0];
  assign o_good   = (best_len_q >= LenW'(MIN_WIN));

endmodule

// File: rtl/ecpddr_rdlevel.sv
// Read-leveling trainer: sweeps READCLKSEL on all lanes, issues NREPEAT test reads per code,
// checks BURSTDET and data, then drives each lane to the centre of its best window.
module ecpddr_rdlevel
  import ecpddr_rdlevel_pkg::*;
#(
  parameter int unsigned NLANES       = 2,
  parameter int unsigned RDLY_W       = 3,
  parameter int unsigned NREPEAT      = 4,
  parameter int unsigned SETTLE       = 8,   // must be at least 1
  parameter int unsigned TIMEOUT      = 255,
  parameter int unsigned MIN_WIN      = 2,
  parameter logic [31:0] PATTERN      = DefaultPattern,
  parameter int unsigned DEFAULT_RDLY = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [NLANES-1:0]        o_fail,
  output logic                     o_timeout,
  output logic [NLANES*RDLY_W-1:0] o_rdly,
  output logic                     o_rd_req,
  input  logic                     i_rd_ack,
  input  logic                     i_rd_valid,
  input  logic [NLANES*32-1:0]     i_rd_data,
  input  logic [NLANES-1:0]        i_burstdet
);

  localparam int unsigned RepW = (NREPEAT > 1) ? $clog2(NREPEAT) : 1;
  localparam int unsigned SetW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [RDLY_W-1:0] DefRdly = RDLY_W'(DEFAULT_RDLY);

  state_e            state_q;
  logic [RDLY_W-1:0] code_q, code_inc;
  logic [RepW-1:0]   rep_q;
  logic [SetW-1:0]   settle_q;
  logic [TmoW-1:0]   timer_q;
  logic [NLANES-1:0] code_ok_q;
  logic [NLANES-1:0] lane_pass;

  logic                           win_clear, win_update, win_last;
  logic [NLANES-1:0][RDLY_W-1:0]  lane_mid;
  logic [NLANES-1:0]              lane_good;
  logic [NLANES*RDLY_W-1:0]       res_rdly;
  logic [NLANES-1:0]              res_fail;

  assign code_inc = code_q + 1'b1;

  // Per-lane verdict for the read currently on the bus.
  always_comb begin
    lane_pass = '0;
    for (int l = 0; l < NLANES; l++) begin
      lane_pass[l] = i_burstdet[l];
      for (int b = 0; b < BeatsPerRead; b++) begin
        if (i_rd_data[byte_lsb(l, b, NLANES) +: 8] != PATTERN[b*8 +: 8]) begin
          lane_pass[l] = 1'b0;
        end
      end
    end
  end

  assign win_clear  = (state_q == StIdle) && i_start;
  assign win_update = (state_q == StEval) && (rep_q == RepW'(NREPEAT - 1));
  assign win_last   = (code_q == '1);

  for (genvar l = 0; l < NLANES; l++) begin : g_lane
    ecpddr_rdlevel_win #(
      .RDLY_W (RDLY_W),
      .MIN_WIN(MIN_WIN)
    ) u_win (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clear (win_clear),
      .i_update(win_update),
      .i_pass  (code_ok_q[l]),
      .i_last  (win_last),
      .i_code  (code_q),
      .o_mid   (lane_mid[l]),
      .o_good  (lane_good[l])
    );
  end

  // Final per-lane code and fail flag, applied in StDone.
  always_comb begin
    res_rdly = '0;
    res_fail = '0;
    for (int l = 0; l < NLANES; l++) begin
      res_fail[l]                   = ~lane_good[l];
      res_rdly[l*RDLY_W +: RDLY_W]  = lane_good[l] ? lane_mid[l] : DefRdly;
    end
  end

  // Training sequencer with registered handshake and result outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= StIdle;
      code_q    <= '0;
      rep_q     <= '0;
      settle_q  <= '0;
      timer_q   <= '0;
      code_ok_q <= '1;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_fail    <= '0;
      o_timeout <= 1'b0;
      o_rd_req  <= 1'b0;
      o_rdly    <= {NLANES{DefRdly}};
    end else begin
      o_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            code_q    <= '0;
            rep_q     <= '0;
            settle_q  <= '0;
            code_ok_q <= '1;
            o_timeout <= 1'b0;
            o_busy    <= 1'b1;
            o_rdly    <= '0;
            state_q   <= StSettle;
          end
        end
        StSettle: begin
          if (settle_q == SetW'(SETTLE - 1)) begin
            settle_q <= '0;
            o_rd_req <= 1'b1;
            state_q  <= StReq;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        StReq: begin
          if (i_rd_ack) begin
            o_rd_req <= 1'b0;
            timer_q  <= '0;
            state_q  <= StWait;
          end
        end
        StWait: begin
          // Data arriving up to TIMEOUT cycles after the ack edge is still accepted.
          if (i_rd_valid) begin
            code_ok_q <= code_ok_q & lane_pass;
            state_q   <= StEval;
          end else if (timer_q == TmoW'(TIMEOUT - 1)) begin
            o_timeout <= 1'b1;
            code_ok_q <= '0;
            state_q   <= StEval;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StEval: begin
          if (rep_q != RepW'(NREPEAT - 1)) begin
            rep_q    <= rep_q + 1'b1;
            o_rd_req <= 1'b1;
            state_q  <= StReq;
          end else if (!win_last) begin
            code_q    <= code_inc;
            rep_q     <= '0;
            code_ok_q <= '1;
            o_rdly    <= {NLANES{code_inc}};
            state_q   <= StSettle;
          end else begin
            state_q <= StDone;
          end
        end
        StDone: begin
          o_rdly  <= res_rdly;
          o_fail  <= res_fail;
          o_done  <= 1'b1;
          o_busy  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
